// File: rtl/idli_pkg.sv
// Shared types for the idli core blocks; currently the UART receiver state encoding.
package idli_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

endpackage : idli_pkg

// File: rtl/idli_uart_rx_if.sv
// EX-side bundle of the UART receiver: nibble stream, read strobe and overflow flag.
interface idli_uart_rx_if;

  logic       rx_vld;
  logic [3:0] rx_data;
  logic       rx_rd;
  logic       rx_ovf;
  logic       ovf_clr;

  // EX consumes nibbles and clears the overflow flag.
  modport master (
    input  rx_vld,
    input  rx_data,
    input  rx_ovf,
    output rx_rd,
    output ovf_clr
  );

  // The receiver produces nibbles and the sticky overflow flag.
  modport slave (
    output rx_vld,
    output rx_data,
    output rx_ovf,
    input  rx_rd,
    input  ovf_clr
  );

endinterface : idli_uart_rx_if

// File: rtl/idli_uart_rx_fifo_m.sv
// Single-clock byte FIFO; pointers carry one extra wrap bit to tell full from empty.
module idli_uart_rx_fifo_m #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A simultaneous pop frees the slot the push needs, so a full FIFO still accepts.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (do_push ? 1'b1 : 1'b0);
    rd_ptr_d = rd_ptr_q + (do_pop  ? 1'b1 : 1'b0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; empty pointers guarantee stale entries are never presented.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule : idli_uart_rx_fifo_m

// File: rtl/idli_uart_rx_m.sv
// 8N1 UART receiver on the ungated clock: synchroniser, bit FSM, byte FIFO and
// a nibble-serial read port for EX with a sticky overflow flag.
module idli_uart_rx_m
  import idli_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_uart_gck,
  input  logic       i_uart_rst_n,
  input  logic       i_uart_rx,
  output logic       o_uart_rx_vld,
  output logic [3:0] o_uart_rx_data,
  input  logic       i_uart_rx_rd,
  output logic       o_uart_rx_ovf,
  input  logic       i_uart_ovf_clr
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]     sync_q, sync_d;
  uart_rx_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           ferr_q, ferr_d;
  logic           hi_q, hi_d;
  logic           ovf_q, ovf_d;

  logic       rx_s;
  logic       sample;
  logic       push;
  logic       pop;
  logic       rd_ok;
  logic       full;
  logic       empty;
  logic [7:0] head;

  assign sync_d = {sync_q[0], i_uart_rx};
  assign rx_s   = sync_q[1];
  assign sample = (cnt_q == '0);

  // NOTE: every flop updates with <= so all state advances from the same pre-edge values.
  always_ff @(posedge i_uart_gck or negedge i_uart_rst_n) begin
    if (!i_uart_rst_n) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      hi_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      hi_q    <= hi_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = sample ? cnt_q : cnt_q - 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    ferr_d  = ferr_q;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end
      START: begin
        if (sample) begin
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = 3'd0;
            cnt_d   = CNT_FULL;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = CNT_FULL;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        // After a bad stop bit the counter stays at 0, polling until the line idles.
        if (sample) begin
          if (rx_s) begin
            state_d = IDLE;
            ferr_d  = 1'b0;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push  = (state_q == STOP) && sample && rx_s && !ferr_q;
    rd_ok = i_uart_rx_rd && !empty;
    pop   = rd_ok && hi_q;
    hi_d  = hi_q ^ rd_ok;
    ovf_d = (push && full && !pop) || (ovf_q && !i_uart_ovf_clr);
  end

  idli_uart_rx_fifo_m #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_uart_gck),
    .rst_n   (i_uart_rst_n),
    .push_i  (push),
    .din_i   (shift_q),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign o_uart_rx_vld  = !empty;
  assign o_uart_rx_data = empty ? 4'h0 : (hi_q ? head[7:4] : head[3:0]);
  assign o_uart_rx_ovf  = ovf_q;

endmodule : idli_uart_rx_m
